// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state, device codes, header fields and status bit indices for i2c_cmd_seq
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WREQ,
        ST_RREQ,
        ST_FLUSH,
        ST_DONE
    } seq_state_t;

    localparam logic [1:0] DEV_DAQ  = 2'd0;
    localparam logic [1:0] DEV_TRG  = 2'd1;
    localparam logic [1:0] DEV_NVIO = 2'd2;
    localparam logic [1:0] DEV_BAD  = 2'd3;

    // Header byte: {dev[7:6], rd[5], cnt[4:0]}
    localparam int HDR_DEV_MSB = 7;
    localparam int HDR_DEV_LSB = 6;
    localparam int HDR_RD_BIT  = 5;
    localparam int HDR_CNT_MSB = 4;
    localparam int HDR_CNT_LSB = 0;

    localparam int STAT_WRT_FULL  = 7;
    localparam int STAT_WRT_EMPTY = 6;
    localparam int STAT_RD_FULL   = 5;
    localparam int STAT_RD_EMPTY  = 4;
    localparam int STAT_NVIO_ERR  = 2;
    localparam int STAT_TRG_ERR   = 1;
    localparam int STAT_DAQ_ERR   = 0;

    // Sticky error bit that a NACK from the given device sets; the invalid code maps to none.
    function automatic logic [2:0] dev_err_mask(input logic [1:0] dev);
        case (dev)
            DEV_DAQ:  dev_err_mask = 3'b001;
            DEV_TRG:  dev_err_mask = 3'b010;
            DEV_NVIO: dev_err_mask = 3'b100;
            default:  dev_err_mask = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/i2c_byte_fifo.sv
// rtl/i2c_byte_fifo.sv - first-word-fall-through byte FIFO with drop-on-full and ignore-on-empty
module i2c_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is forced to zero when empty so the output reads low after a flush.
    assign dout    = empty ? 8'h00 : mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_seq.sv
// rtl/i2c_cmd_seq.sv - header-driven I2C command sequencer; optional scope trigger via I2C_SCOPE_SYNC_EN
module i2c_cmd_seq
    import i2c_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] I2C_WRT_FIFO_DATA,
    input  logic       I2C_WE,
    input  logic       I2C_RDENA,
    input  logic       I2C_RESET,
    input  logic       I2C_START,
    input  logic       BYTE_ACK,
    input  logic [7:0] BYTE_RDATA,
    input  logic       BYTE_NACK,
    output logic [7:0] I2C_RBK_FIFO_DATA,
    output logic       I2C_CLR_START,
    output logic       I2C_SCOPE_SYNC,
    output logic [7:0] I2C_STATUS,
    output logic       BYTE_REQ,
    output logic [1:0] BYTE_DEV,
    output logic       BYTE_RD,
    output logic       BYTE_LAST,
    output logic [7:0] BYTE_WDATA,
    output logic       BUSY
);
    seq_state_t state;
    logic [4:0] remaining;
    logic [2:0] err_q;

    logic       soft_rst;
    logic [7:0] wrt_head;
    logic       wrt_full;
    logic       wrt_empty;
    logic       wrt_pop;
    logic       rbk_full;
    logic       rbk_empty;
    logic       rbk_push;
    logic       txn_end;

    logic [1:0] hdr_dev;
    logic       hdr_rd;
    logic [4:0] hdr_cnt;

    assign soft_rst = RST || I2C_RESET;
    assign hdr_dev  = wrt_head[HDR_DEV_MSB:HDR_DEV_LSB];
    assign hdr_rd   = wrt_head[HDR_RD_BIT];
    assign hdr_cnt  = wrt_head[HDR_CNT_MSB:HDR_CNT_LSB];
    assign BUSY     = (state != ST_IDLE);
    // An ACK only counts while a request is outstanding.
    assign rbk_push = (state == ST_RREQ) && BYTE_REQ && BYTE_ACK;
    assign txn_end  = BYTE_NACK || (remaining == 5'd1);

    i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_wrt_fifo (
        .clk   (CLK),
        .rst   (soft_rst),
        .push  (I2C_WE),
        .din   (I2C_WRT_FIFO_DATA),
        .pop   (wrt_pop),
        .dout  (wrt_head),
        .full  (wrt_full),
        .empty (wrt_empty)
    );

    i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rbk_fifo (
        .clk   (CLK),
        .rst   (soft_rst),
        .push  (rbk_push),
        .din   (BYTE_RDATA),
        .pop   (I2C_RDENA),
        .dout  (I2C_RBK_FIFO_DATA),
        .full  (rbk_full),
        .empty (rbk_empty)
    );

    // Write-FIFO consumption: headers in HDR, data as each write request is raised, discards in FLUSH.
    always_comb begin
        wrt_pop = 1'b0;
        case (state)
            ST_HDR, ST_FLUSH: wrt_pop = !wrt_empty;
            ST_WREQ:          wrt_pop = !wrt_empty && !BYTE_REQ;
            default:          wrt_pop = 1'b0;
        endcase
    end

    // Status word assembled from FIFO flags and sticky per-device NACK errors.
    always_comb begin
        I2C_STATUS                 = 8'h00;
        I2C_STATUS[STAT_WRT_FULL]  = wrt_full;
        I2C_STATUS[STAT_WRT_EMPTY] = wrt_empty;
        I2C_STATUS[STAT_RD_FULL]   = rbk_full;
        I2C_STATUS[STAT_RD_EMPTY]  = rbk_empty;
        I2C_STATUS[STAT_NVIO_ERR]  = err_q[DEV_NVIO];
        I2C_STATUS[STAT_TRG_ERR]   = err_q[DEV_TRG];
        I2C_STATUS[STAT_DAQ_ERR]   = err_q[DEV_DAQ];
    end

    // Sequencer: walks headers, issues byte requests with a one-cycle gap after each ACK.
    always_ff @(posedge CLK) begin
        if (soft_rst) begin
            state         <= ST_IDLE;
            remaining     <= '0;
            err_q         <= '0;
            BYTE_REQ      <= 1'b0;
            BYTE_DEV      <= 2'd0;
            BYTE_RD       <= 1'b0;
            BYTE_LAST     <= 1'b0;
            BYTE_WDATA    <= 8'h00;
            I2C_CLR_START <= 1'b0;
        end else begin
            I2C_CLR_START <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (I2C_START) begin
                        state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (wrt_empty) begin
                        state         <= ST_DONE;
                        I2C_CLR_START <= 1'b1;
                    end else begin
                        remaining <= hdr_cnt;
                        if (hdr_cnt == 5'd0 || hdr_dev == DEV_BAD) begin
                            // Skipped write headers still own their data bytes.
                            state <= (!hdr_rd && hdr_cnt != 5'd0) ? ST_FLUSH : ST_HDR;
                        end else begin
                            BYTE_DEV <= hdr_dev;
                            BYTE_RD  <= hdr_rd;
                            state    <= hdr_rd ? ST_RREQ : ST_WREQ;
                        end
                    end
                end
                ST_WREQ: begin
                    if (!BYTE_REQ) begin
                        if (wrt_empty) begin
                            state         <= ST_DONE;
                            I2C_CLR_START <= 1'b1;
                        end else begin
                            BYTE_REQ   <= 1'b1;
                            BYTE_WDATA <= wrt_head;
                            BYTE_LAST  <= (remaining == 5'd1);
                        end
                    end else if (BYTE_ACK) begin
                        BYTE_REQ  <= 1'b0;
                        BYTE_LAST <= 1'b0;
                        if (BYTE_NACK) begin
                            err_q <= err_q | dev_err_mask(BYTE_DEV);
                        end
                        if (remaining == 5'd1) begin
                            state <= ST_HDR;
                        end else begin
                            remaining <= remaining - 5'd1;
                            if (BYTE_NACK) begin
                                state <= ST_FLUSH;
                            end
                        end
                    end
                end
                ST_RREQ: begin
                    if (!BYTE_REQ) begin
                        BYTE_REQ  <= 1'b1;
                        BYTE_LAST <= (remaining == 5'd1);
                    end else if (BYTE_ACK) begin
                        BYTE_REQ  <= 1'b0;
                        BYTE_LAST <= 1'b0;
                        if (BYTE_NACK) begin
                            err_q <= err_q | dev_err_mask(BYTE_DEV);
                        end
                        if (txn_end) begin
                            state <= ST_HDR;
                        end else begin
                            remaining <= remaining - 5'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (wrt_empty) begin
                        state         <= ST_DONE;
                        I2C_CLR_START <= 1'b1;
                    end else if (remaining == 5'd1) begin
                        state <= ST_HDR;
                    end else begin
                        remaining <= remaining - 5'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef I2C_SCOPE_SYNC_EN
    logic scope_q;

    // One-cycle trigger coincident with leaving IDLE.
    always_ff @(posedge CLK) begin
        if (soft_rst) begin
            scope_q <= 1'b0;
        end else begin
            scope_q <= (state == ST_IDLE) && I2C_START;
        end
    end

    assign I2C_SCOPE_SYNC = scope_q;
`else
    assign I2C_SCOPE_SYNC = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// tb/tb_i2c_cmd_seq.sv - directed self-checking bench for i2c_cmd_seq
`timescale 1ns/1ps
module tb_i2c_cmd_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = 8'h00;
    logic       we = 1'b0;
    logic       rdena = 1'b0;
    logic       i2c_reset = 1'b0;
    logic       start = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic       nack = 1'b0;

    logic [7:0] rbk_data;
    logic       clr_start;
    logic       scope_sync;
    logic [7:0] status;
    logic       byte_req;
    logic [1:0] byte_dev;
    logic       byte_rd;
    logic       byte_last;
    logic [7:0] byte_wdata;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int clr_cnt = 0;
    int scope_cnt = 0;
    int req_rise = 0;
    logic req_prev = 1'b0;
    int snap_clr;
    int snap_req;
    int snap_scope;
    int exp_scope_per_start;

    i2c_cmd_seq #(.FIFO_DEPTH(16)) dut (
        .CLK               (clk),
        .RST               (rst),
        .I2C_WRT_FIFO_DATA (wdata),
        .I2C_WE            (we),
        .I2C_RDENA         (rdena),
        .I2C_RESET         (i2c_reset),
        .I2C_START         (start),
        .BYTE_ACK          (ack),
        .BYTE_RDATA        (rdata),
        .BYTE_NACK         (nack),
        .I2C_RBK_FIFO_DATA (rbk_data),
        .I2C_CLR_START     (clr_start),
        .I2C_SCOPE_SYNC    (scope_sync),
        .I2C_STATUS        (status),
        .BYTE_REQ          (byte_req),
        .BYTE_DEV          (byte_dev),
        .BYTE_RD           (byte_rd),
        .BYTE_LAST         (byte_last),
        .BYTE_WDATA        (byte_wdata),
        .BUSY              (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clr_start) clr_cnt++;
        if (scope_sync) scope_cnt++;
        if (byte_req && !req_prev) req_rise++;
        req_prev = byte_req;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        we = 1'b1;
        wdata = b;
        tick();
        we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pop_rbk();
        rdena = 1'b1;
        tick();
        rdena = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (!byte_req && k < 100) begin
            tick();
            k++;
        end
        check_eq({tag, "_req"}, byte_req, 1);
    endtask

    // Plays the byte engine: waits for a request, holds it one cycle, checks fields, then ACKs.
    task automatic serve(input string tag, input logic [1:0] dev, input logic rd, input logic last,
                         input logic [7:0] wd, input logic [7:0] rd_byte, input logic nk);
        wait_req(tag);
        tick();
        check_eq({tag, "_hold"}, byte_req, 1);
        check_eq({tag, "_dev"}, byte_dev, dev);
        check_eq({tag, "_rd"}, byte_rd, rd);
        check_eq({tag, "_last"}, byte_last, last);
        if (!rd) check_eq({tag, "_wdata"}, byte_wdata, wd);
        ack = 1'b1;
        rdata = rd_byte;
        nack = nk;
        tick();
        ack = 1'b0;
        nack = 1'b0;
        check_eq({tag, "_reqlow"}, byte_req, 0);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        check_eq({tag, "_idle"}, busy, 0);
        tick();
    endtask

    initial begin
`ifdef I2C_SCOPE_SYNC_EN
        exp_scope_per_start = 1;
`else
        exp_scope_per_start = 0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_eq("rst_status", status, 8'h50);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_req", byte_req, 0);
        check_eq("rst_clr", clr_start, 0);
        check_eq("rst_rbk", rbk_data, 8'h00);
        // Stray ACK with no request must not load the readback FIFO
        ack = 1'b1;
        rdata = 8'h77;
        tick();
        ack = 1'b0;
        tick();
        check_eq("stray_ack_status", status, 8'h50);

        // Write transaction to TRG
        push(8'h42); push(8'hA5); push(8'h5A);
        snap_clr = clr_cnt;
        snap_scope = scope_cnt;
        go();
        serve("wr0", 2'd1, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0);
        serve("wr1", 2'd1, 1'b0, 1'b1, 8'h5A, 8'h00, 1'b0);
        wait_idle("wr");
        check_eq("wr_clr", clr_cnt - snap_clr, 1);
        check_eq("wr_scope", scope_cnt - snap_scope, exp_scope_per_start);
        check_eq("wr_status", status, 8'h50);

        // Read transaction from NVIO, with an ignored start while busy
        push(8'hA3);
        snap_clr = clr_cnt;
        go();
        serve("rd0", 2'd2, 1'b1, 1'b0, 8'h00, 8'h11, 1'b0);
        go();
        serve("rd1", 2'd2, 1'b1, 1'b0, 8'h00, 8'h22, 1'b0);
        serve("rd2", 2'd2, 1'b1, 1'b1, 8'h00, 8'h33, 1'b0);
        wait_idle("rd");
        check_eq("rd_clr", clr_cnt - snap_clr, 1);
        check_eq("rd_status", status, 8'h40);
        check_eq("rd_head0", rbk_data, 8'h11);
        pop_rbk();
        check_eq("rd_head1", rbk_data, 8'h22);
        pop_rbk();
        check_eq("rd_head2", rbk_data, 8'h33);
        pop_rbk();
        check_eq("rd_empty", status, 8'h50);

        // Write with NACK on the first byte: remaining bytes flushed
        push(8'h03); push(8'h01); push(8'h02); push(8'h03);
        snap_clr = clr_cnt;
        snap_req = req_rise;
        go();
        serve("nk0", 2'd0, 1'b0, 1'b0, 8'h01, 8'h00, 1'b1);
        wait_idle("nk");
        check_eq("nk_reqs", req_rise - snap_req, 1);
        check_eq("nk_clr", clr_cnt - snap_clr, 1);
        check_eq("nk_status", status, 8'h51);
        i2c_reset = 1'b1;
        tick();
        i2c_reset = 1'b0;
        check_eq("nk_softrst_status", status, 8'h50);

        // Skipped headers: cnt=0, then invalid device with two data bytes
        push(8'h40); push(8'hC2); push(8'hAA); push(8'hBB); push(8'h41); push(8'hCC);
        snap_req = req_rise;
        go();
        serve("sk0", 2'd1, 1'b0, 1'b1, 8'hCC, 8'h00, 1'b0);
        wait_idle("sk");
        check_eq("sk_reqs", req_rise - snap_req, 1);
        check_eq("sk_status", status, 8'h50);

        // Write FIFO overflow: 17th byte (a read header) must be lost
        push(8'h4F);
        for (int i = 0; i < 15; i++) push(8'(8'h10 + i));
        push(8'h61);
        check_eq("full_status", status, 8'h90);
        snap_req = req_rise;
        go();
        for (int i = 0; i < 15; i++)
            serve($sformatf("fw%0d", i), 2'd1, 1'b0, (i == 14), 8'(8'h10 + i), 8'h00, 1'b0);
        wait_idle("fw");
        check_eq("fw_reqs", req_rise - snap_req, 15);
        check_eq("fw_status", status, 8'h50);

        // Readback FIFO overflow: 17 reads into a 16-deep FIFO
        push(8'h31);
        go();
        for (int i = 0; i < 17; i++)
            serve($sformatf("fr%0d", i), 2'd0, 1'b1, (i == 16), 8'h00, 8'(i + 1), 1'b0);
        wait_idle("fr");
        check_eq("fr_status", status, 8'h60);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("fr_head%0d", i), rbk_data, 8'(i + 1));
            pop_rbk();
        end
        pop_rbk();
        check_eq("fr_drain_status", status, 8'h50);
        check_eq("fr_drain_head", rbk_data, 8'h00);

        // Soft reset during a read request
        push(8'hA1);
        go();
        wait_req("mr");
        snap_clr = clr_cnt;
        i2c_reset = 1'b1;
        tick();
        i2c_reset = 1'b0;
        check_eq("mr_req", byte_req, 0);
        check_eq("mr_busy", busy, 0);
        check_eq("mr_status", status, 8'h50);
        repeat (5) tick();
        check_eq("mr_clr", clr_cnt - snap_clr, 0);

        // Seven accepted starts in total
        check_eq("scope_total", scope_cnt, 7 * exp_scope_per_start);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
